fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer: owns the program counter that drives the instruction ROM/decoder and consumes its decoded opcode to choose the next PC.
- Handles sequential flow, JMP, BNE/BEQ/BLT, HALT and back-pressure from the execute/memory stage.
- Reports halt, timeout and retired-instruction count to the testbench/top level.

Parameters:
- PC_RESET, 16'h0000, PC loaded on reset and on restart.
- MAX_INSTR, 16'd0, watchdog limit on retired instructions; 0 = disabled.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; begin/restart execution.
- opcode  input  4  decoded opcode of instruction at current pc (combinational from ROM).
- eq_flag  input  1  ALU compare result: operands equal.
- lt_flag  input  1  ALU compare result: op1 < op2, unsigned.
- target_addr  input  16  jump/branch destination from register file.
- stall  input  1  execute/memory not ready; hold current instruction.
- pc  output  16  program counter to ROM.
- fetch_valid  output  1  current instruction retires this cycle.
- halted  output  1  HALT reached or watchdog fired.
- timeout  output  1  watchdog caused halt.
- instr_count  output  16  retired instructions, saturating.

Behaviour:
- Reset (synchronous, reset=1 at edge): state=IDLE, pc=PC_RESET, halted=0, timeout=0, instr_count=0. fetch_valid=0 (combinational, 0 outside RUN). reset has priority over all inputs, including mid-RUN and during stall.
- States: IDLE, RUN, HALT.
- IDLE: pc holds. start=1 -> RUN next cycle.
- RUN: fetch_valid = ~stall.
  - stall=1: pc, count and state hold; no opcode is acted on.
  - stall=0: instruction retires.
  - instr_count increments and saturates at 16'hFFFF.
- Next-pc priority when retiring:
  - HALT_OP (4'b1110): pc holds, -> HALT, halted=1.
  - JMP_OP (4'b0010): pc=target_addr.
  - BNE_OP (4'b1010): pc = ~eq_flag ? target_addr : pc+1.
  - BEQ_OP (4'b1011): pc = eq_flag ? target_addr : pc+1.
  - BLT_OP (4'b1100): pc = lt_flag ? target_addr : pc+1.
  - All other opcodes, including TBA_OP: pc = pc+1.
- pc arithmetic is 16-bit modulo: 16'hFFFF+1 -> 16'h0000, no flag.
- Watchdog (MAX_INSTR!=0):
  - Triggers when a retire makes instr_count equal MAX_INSTR: -> HALT, halted=1, timeout=1.
  - pc still takes the computed next value for that retire.
  - A HALT_OP on the same retire sets halted=1 and timeout=1 (watchdog wins the flag).
- HALT: pc, count and flags hold; fetch_valid=0; stall ignored.
  - start=1 -> RUN next cycle with pc=PC_RESET, instr_count=0, halted=0, timeout=0.
- start is ignored in RUN.
- Latency: next pc visible one cycle after the retiring edge. opcode is sampled the same cycle pc is presented (ROM is combinational).

Test Plan:
- Sequential: reset, start=1, opcodes LIM, INC, LIM, SFT, MVF (stall=0) then HALT -> pc 0,1,2,3,4,5 on successive cycles; halted=1 with pc=5; instr_count=6; fetch_valid low thereafter.
- Branches:
  - At pc=3, BEQ with eq_flag=1, target_addr=16'h0040 -> pc=16'h0040.
  - BNE with eq_flag=1 -> pc=16'h0041.
  - BLT with lt_flag=1, target_addr=16'h0010 -> pc=16'h0010.
  - JMP with target_addr=16'hFFFF -> pc=16'hFFFF; next NOP -> pc=16'h0000.
- Stall: in RUN at pc=2, hold stall=1 for 3 cycles with opcode=JMP -> pc stays 2, fetch_valid=0, count unchanged; stall drops -> pc=target_addr, count+1.
- Watchdog: MAX_INSTR=4, stream of ADD opcodes -> after 4th retire halted=1, timeout=1, pc=4, instr_count=4; start=1 -> pc=0, count=0, flags clear, RUN.
- Reset mid-operation: reset=1 during stall at pc=16'h0123 -> next cycle pc=PC_RESET, state IDLE, count=0; start must be reasserted to run.
- Simultaneous: HALT_OP retiring as count reaches MAX_INSTR -> halted=1, timeout=1, pc holds.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-sequencer bus: ROM/decoder and execute-stage inputs, PC and status outputs.
interface fetch_ctrl_if;
  logic        start;
  logic [3:0]  opcode;
  logic        eq_flag;
  logic        lt_flag;
  logic [15:0] target_addr;
  logic        stall;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        halted;
  logic        timeout;
  logic [15:0] instr_count;

  modport master (
    output start, opcode, eq_flag, lt_flag, target_addr, stall,
    input  pc, fetch_valid, halted, timeout, instr_count
  );

  modport slave (
    input  start, opcode, eq_flag, lt_flag, target_addr, stall,
    output pc, fetch_valid, halted, timeout, instr_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, retires one instruction per unstalled RUN cycle.
// Next PC is registered one cycle after the retiring edge; stall freezes pc, count and state.
module fetch_ctrl #(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter logic [15:0] MAX_INSTR = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  fetch_ctrl_if.slave bus
);
  localparam logic [3:0] JMP_OP  = 4'b0010;
  localparam logic [3:0] BNE_OP  = 4'b1010;
  localparam logic [3:0] BEQ_OP  = 4'b1011;
  localparam logic [3:0] BLT_OP  = 4'b1100;
  localparam logic [3:0] HALT_OP = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic        r_halted, w_halted_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic [15:0] w_pc_inc;
  logic [15:0] w_count_inc;
  logic        w_taken;
  logic        w_wdog;

  assign w_pc_inc    = r_pc + 16'd1;
  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
  assign w_wdog      = (MAX_INSTR != 16'd0) && (w_count_inc == MAX_INSTR);

  always_comb begin
    w_taken = 1'b0;
    case (bus.opcode)
      JMP_OP:  w_taken = 1'b1;
      BNE_OP:  w_taken = ~bus.eq_flag;
      BEQ_OP:  w_taken = bus.eq_flag;
      BLT_OP:  w_taken = bus.lt_flag;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_count_nxt   = r_count;
    w_halted_nxt  = r_halted;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!bus.stall) begin
          w_count_nxt = w_count_inc;
          if (bus.opcode == HALT_OP) begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_taken ? bus.target_addr : w_pc_inc;
          end
          // Watchdog overrides a simultaneous HALT_OP only in the timeout flag.
          if (w_wdog) begin
            w_state_nxt   = S_HALT;
            w_halted_nxt  = 1'b1;
            w_timeout_nxt = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (bus.start) begin
          w_state_nxt   = S_RUN;
          w_pc_nxt      = PC_RESET;
          w_count_nxt   = 16'd0;
          w_halted_nxt  = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= PC_RESET;
      r_count   <= 16'd0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_count   <= w_count_nxt;
      r_halted  <= w_halted_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.fetch_valid = (r_state == S_RUN) && !bus.stall;
  assign bus.halted      = r_halted;
  assign bus.timeout     = r_timeout;
  assign bus.instr_count = r_count;
endmodule
